// File: rtl/fga_pkg.sv
// Shared constants and types for the screen write path: register map,
// display modes, text geometry and write-engine FSM states.
package fga_pkg;

  localparam logic [3:0] REG_MODE  = 4'd0;
  localparam logic [3:0] REG_DATA  = 4'd1;
  localparam logic [3:0] REG_FILL  = 4'd2;
  localparam logic [3:0] REG_CURLO = 4'd3;
  localparam logic [3:0] REG_CURHI = 4'd4;
  localparam logic [3:0] REG_CTRL  = 4'd5;

  typedef enum logic [1:0] {
    MODE_TEXT0   = 2'd0,
    MODE_TEXT1   = 2'd1,
    MODE_BITMAP2 = 2'd2,
    MODE_BITMAP3 = 2'd3
  } mode_t;

  localparam int unsigned TXT_COLS = 80;
  localparam int unsigned TXT_ROWS = 60;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO for pending screen writes; a pop frees its slot for a
// push on the same edge, so a full FIFO can accept while draining.
module wr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/screen_write_ctrl.sv
// Host-to-screen-RAM write engine: register file, auto-incrementing cursor,
// write FIFO and the hardware clear-screen sequencer.
module screen_write_ctrl
  import fga_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [15:0] CLR_LAST = 16'h1DFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_stb,
  input  logic [3:0]  wr_rs,
  input  logic [7:0]  wr_data,
  input  logic        ram_wr_allow,
  output logic [15:0] ram_wraddr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  output logic [1:0]  mode,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam logic [7:0] X_LAST = 8'(TXT_COLS - 1);
  localparam logic [7:0] Y_LAST = 8'(TXT_ROWS - 1);

  logic [7:0]  cur_lo;
  logic [7:0]  cur_hi;
  logic [7:0]  nxt_lo;
  logic [7:0]  nxt_hi;
  logic [7:0]  fill;
  logic        auto_inc;
  logic [15:0] cur_addr;
  logic [15:0] clr_cnt;
  state_t      state;

  logic        data_wr;
  logic        clr_req;
  logic        drain;
  logic        push_ok;
  logic        fifo_empty;
  logic [23:0] fifo_dout;

  assign data_wr = wr_stb && (wr_rs == REG_DATA);
  assign clr_req = wr_stb && (wr_rs == REG_CTRL) && wr_data[1];
  assign drain   = ram_wr_allow && (state != ST_CLEAR) && !fifo_empty;
  assign push_ok = data_wr && (!fifo_full || drain);
  assign busy    = !fifo_empty || (state != ST_IDLE);

  // mode[1] selects the linear bitmap addressing; modes 0/1 use XY text cells.
  assign cur_addr = mode[1] ? {cur_hi, cur_lo} : {1'b0, cur_hi, cur_lo[6:0]};

  always_comb begin
    nxt_lo = cur_lo;
    nxt_hi = cur_hi;
    if (mode[1]) begin
      {nxt_hi, nxt_lo} = {cur_hi, cur_lo} + 16'd1;
    end else if (cur_lo >= X_LAST) begin
      nxt_lo = '0;
      nxt_hi = (cur_hi >= Y_LAST) ? '0 : cur_hi + 8'd1;
    end else begin
      nxt_lo = cur_lo + 8'd1;
    end
  end

  wr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(24)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (drain),
    .din   ({cur_addr, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= '0;
      cur_lo   <= '0;
      cur_hi   <= '0;
      fill     <= '0;
      auto_inc <= 1'b1;
      overflow <= 1'b0;
    end else if (wr_stb) begin
      case (wr_rs)
        REG_MODE:  mode <= wr_data[1:0];
        REG_DATA: begin
          if (!push_ok) begin
            overflow <= 1'b1;
          end else if (auto_inc) begin
            cur_lo <= nxt_lo;
            cur_hi <= nxt_hi;
          end
        end
        REG_FILL:  fill   <= wr_data;
        REG_CURLO: cur_lo <= wr_data;
        REG_CURHI: cur_hi <= wr_data;
        REG_CTRL: begin
          auto_inc <= wr_data[0];
          if (wr_data[2]) overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_data   <= '0;
    end else begin
      ram_wren <= 1'b0;
      if (drain) begin
        ram_wren               <= 1'b1;
        {ram_wraddr, ram_data} <= fifo_dout;
      end
      case (state)
        ST_IDLE: begin
          if (clr_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          // Fill is read live so a mid-clear change applies from the next address.
          if (ram_wr_allow) begin
            ram_wren   <= 1'b1;
            ram_wraddr <= clr_cnt;
            ram_data   <= fill;
            clr_cnt    <= clr_cnt + 16'd1;
            if (clr_cnt == CLR_LAST) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
